// File: rtl/tea_crypt_core.sv
// Iterative TEA block cipher core with per-block encrypt/decrypt selection.
// UNROLL TEA cycles are chained per clock; the result is held until out_ready.
module tea_crypt_core #(
  parameter int NUM_ROUNDS = 32,
  parameter int UNROLL     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [31:0]  y_in,
  input  logic [31:0]  z_in,
  input  logic [127:0] key,
  input  logic [31:0]  delta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data,
  output logic         done,
  output logic         busy
);

  localparam int UNROLL_SAFE = (UNROLL < 1) ? 1 : UNROLL;
  localparam int GROUPS      = (NUM_ROUNDS < 1) ? 1 : NUM_ROUNDS / UNROLL_SAFE;
  localparam int CW          = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST_GROUP = CW'(GROUPS - 1);

  generate
    if (NUM_ROUNDS < 1 || UNROLL < 1 || (NUM_ROUNDS % UNROLL_SAFE) != 0) begin : g_bad_params
      $error("tea_crypt_core: UNROLL must be >=1 and divide NUM_ROUNDS (>=1)");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   y_reg, z_reg, sum_reg, delta_reg;
  logic [127:0]  key_reg;
  logic          mode_reg;
  logic [63:0]  data_reg;
  logic          done_reg;

  logic [31:0] k0, k1, k2, k3;
  assign k0 = key_reg[127:96];
  assign k1 = key_reg[95:64];
  assign k2 = key_reg[63:32];
  assign k3 = key_reg[31:0];

  function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // Combinational chain of UNROLL TEA cycles; each stage feeds the next.
  genvar gi;
  generate
    for (gi = 0; gi < UNROLL_SAFE; gi++) begin : g_round
      logic [31:0] y_i, z_i, s_i;
      logic [31:0] y_o, z_o, s_o;
      logic [31:0] s_enc, y_enc, z_enc, y_dec, z_dec;

      if (gi == 0) begin : g_first
        assign y_i = y_reg;
        assign z_i = z_reg;
        assign s_i = sum_reg;
      end else begin : g_next
        assign y_i = g_round[gi-1].y_o;
        assign z_i = g_round[gi-1].z_o;
        assign s_i = g_round[gi-1].s_o;
      end

      assign s_enc = s_i + delta_reg;
      assign y_enc = y_i + tea_f(z_i, s_enc, k0, k1);
      assign z_enc = z_i + tea_f(y_enc, s_enc, k2, k3);
      // Decrypt undoes the halves in reverse order, sum steps down after use.
      assign z_dec = z_i - tea_f(y_i, s_i, k2, k3);
      assign y_dec = y_i - tea_f(z_dec, s_i, k0, k1);

      assign y_o = mode_reg ? y_dec : y_enc;
      assign z_o = mode_reg ? z_dec : z_enc;
      assign s_o = mode_reg ? (s_i - delta_reg) : s_enc;
    end
  endgenerate

  logic [31:0] y_last, z_last, s_last;
  assign y_last = g_round[UNROLL_SAFE-1].y_o;
  assign z_last = g_round[UNROLL_SAFE-1].z_o;
  assign s_last = g_round[UNROLL_SAFE-1].s_o;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_RUN;
      ST_RUN:  if (cnt_reg == LAST_GROUP) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            y_reg     <= y_in;
            z_reg     <= z_in;
            key_reg   <= key;
            delta_reg <= delta;
            mode_reg  <= mode;
            cnt_reg   <= '0;
            sum_reg   <= mode ? delta * 32'(NUM_ROUNDS) : 32'h0;
          end
        end
        ST_RUN: begin
          y_reg   <= y_last;
          z_reg   <= z_last;
          sum_reg <= s_last;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_GROUP) begin
            data_reg <= {y_last, z_last};
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_RUN);
  assign done      = done_reg;
  assign data      = data_reg;

endmodule

// File: tb/tb_tea_crypt_core.sv
// Directed bench for tea_crypt_core: a default build and an UNROLL=4 build run side by side
// on the same blocks, checked against constants and a plain TEA reference function.
module tb_tea_crypt_core;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst, in_valid, mode, out_ready;
  logic [31:0]  y_in, z_in, delta;
  logic [127:0] key;
  logic         in_ready1, out_valid1, done1, busy1;
  logic         in_ready4, out_valid4, done4, busy4;
  logic [63:0]  data1, data4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tea_crypt_core u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .mode(mode),
    .y_in(y_in), .z_in(z_in), .key(key), .delta(delta), .out_valid(out_valid1),
    .out_ready(out_ready), .data(data1), .done(done1), .busy(busy1)
  );

  tea_crypt_core #(.NUM_ROUNDS(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .mode(mode),
    .y_in(y_in), .z_in(z_in), .key(key), .delta(delta), .out_valid(out_valid4),
    .out_ready(out_ready), .data(data4), .done(done4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Straightforward 32-cycle TEA as written in the reference description.
  function automatic logic [63:0] tea_model(input logic dec, input logic [63:0] v,
                                            input logic [127:0] k, input logic [31:0] d);
    logic [31:0] y, z, s, k0, k1, k2, k3;
    y = v[63:32]; z = v[31:0];
    k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
    s = dec ? d * 32'd32 : 32'h0;
    for (int r = 0; r < 32; r++) begin
      if (!dec) begin
        s = s + d;
        y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
        z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
      end else begin
        z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
        y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
        s = s - d;
      end
    end
    return {y, z};
  endfunction

  task automatic run_block(input string tag, input logic m, input logic [127:0] k,
                           input logic [63:0] pt, input logic [63:0] exp, input int hold);
    int cyc, lat1, lat4, busy1_n, busy4_n, done1_n, done4_n, hold_bad;
    lat1 = 0; lat4 = 0; busy1_n = 0; busy4_n = 0; done1_n = 0; done4_n = 0; hold_bad = 0;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'({in_ready1, in_ready4}), 64'h3);
    in_valid = 1'b1; mode = m; key = k; y_in = pt[63:32]; z_in = pt[31:0]; delta = DELTA;
    @(posedge clk); #1;
    // Scramble inputs after accept: the core must work from its latched copy.
    in_valid = 1'b0; mode = ~m; y_in = $urandom; z_in = $urandom; delta = $urandom;
    key = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while ((lat1 == 0 || lat4 == 0) && cyc < 100) begin
      if (busy1) busy1_n++;
      if (busy4) busy4_n++;
      if (done1) done1_n++;
      if (done4) done4_n++;
      if (out_valid1 && lat1 == 0) lat1 = cyc;
      if (out_valid4 && lat4 == 0) lat4 = cyc;
      if (lat1 == 0 || lat4 == 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_lat_u1"}, 64'(lat1), 64'd33);
    check({tag, "_lat_u4"}, 64'(lat4), 64'd9);
    check({tag, "_data_u1"}, data1, exp);
    check({tag, "_data_u4"}, data4, exp);
    check({tag, "_busy_cycles"}, 64'({16'(busy1_n), 16'(busy4_n)}), {32'h0, 16'd32, 16'd8});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; y_in = $urandom; z_in = $urandom;
      @(posedge clk); #1;
      if (done1) done1_n++;
      if (done4) done4_n++;
      if (data1 !== exp || data4 !== exp || !out_valid1 || !out_valid4 ||
          in_ready1 || in_ready4 || busy1 || busy4) hold_bad++;
    end
    in_valid = 1'b0;
    check({tag, "_hold_bad"}, 64'(hold_bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_done_pulses"}, 64'({16'(done1_n), 16'(done4_n)}), {32'h0, 16'd1, 16'd1});
    check({tag, "_after_release"},
          64'({in_ready1, out_valid1, done1, busy1, in_ready4, out_valid4, done4, busy4}),
          64'b1000_1000);
    check({tag, "_data_kept_idle"}, data1 ^ data4 ^ exp, exp);
    $display("txn %s mode=%0d data_u1=%h data_u4=%h lat=%0d/%0d", tag, m, data1, data4, lat1, lat4);
  endtask

  logic [127:0] key3;
  logic [63:0]  pt3, ct3;

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
    y_in = '0; z_in = '0; key = '0; delta = DELTA;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({in_ready1, out_valid1, done1, busy1, in_ready4, out_valid4, done4, busy4}),
          64'b1000_1000);
    check("reset_data", data1 | data4, 64'h0);
    @(negedge clk); rst = 1'b0;

    // T1 / T2: all-zero key and block, then decrypt it back
    run_block("t1_enc", 1'b0, 128'h0, 64'h0, 64'h41EA3A0A_94BAA940, 0);
    run_block("t2_dec", 1'b1, 128'h0, 64'h41EA3A0A_94BAA940, 64'h0, 0);

    // T3: nonzero key round trip
    key3 = 128'h95b3a174_46cf51e1_d8c4f6b4_93a71922;
    pt3  = 64'h2cdc0ff5_427e1e21;
    ct3  = tea_model(1'b0, pt3, key3, DELTA);
    run_block("t3_enc", 1'b0, key3, pt3, ct3, 0);
    run_block("t3_dec", 1'b1, key3, ct3, pt3, 0);

    // T5: consumer stalls for 10 clocks while in_valid keeps knocking
    run_block("t5_stall", 1'b0, 128'h0, 64'h0, 64'h41EA3A0A_94BAA940, 10);

    // T6: reset at round 10 with in_valid asserted in the reset cycle
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b0; key = 128'h0; y_in = '0; z_in = '0; delta = DELTA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("t6_busy_before_rst", 64'(busy1), 64'd1);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("t6_after_rst", 64'({in_ready1, out_valid1, done1, busy1, in_ready4, out_valid4, done4, busy4}),
          64'b1000_1000);
    check("t6_data_cleared", data1 | data4, 64'h0);
    @(posedge clk); #1;
    check("t6_still_idle", 64'({in_ready1, busy1, in_ready4, busy4}), 64'b1010);
    $display("txn t6_reset in_ready=%0d/%0d busy=%0d/%0d", in_ready1, in_ready4, busy1, busy4);
    run_block("t6_fresh", 1'b0, 128'h0, 64'h0, 64'h41EA3A0A_94BAA940, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
